// File: rtl/sprite_pkg.sv
// Shared types for the sprite table: descriptor field layout, decoded entry,
// per-line slot record and scan FSM states.
package sprite_pkg;
    localparam int N_SLOTS   = 4;
    localparam int SPR_LOG2  = 5;
    localparam int SPR_SIZE  = 1 << SPR_LOG2;
    localparam int N_ENTRIES = 8;

    localparam int D_EN       = 31;
    localparam int D_SHEET_HI = 30;
    localparam int D_SHEET_LO = 27;
    localparam int D_FLIP     = 26;
    localparam int D_X_HI     = 25;
    localparam int D_X_LO     = 16;
    localparam int D_Y_HI     = 15;
    localparam int D_Y_LO     = 6;
    localparam int D_ROW_HI   = 5;
    localparam int D_ROW_LO   = 3;
    localparam int D_COL_HI   = 2;
    localparam int D_COL_LO   = 0;

    typedef struct packed {
        logic       en;
        logic [3:0] sheet;
        logic       flip;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] row;
        logic [2:0] col;
    } spr_entry_t;

    typedef struct packed {
        logic [9:0]          x;
        logic [3:0]          sheet;
        logic                flip;
        logic [2:0]          row;
        logic [2:0]          col;
        logic [SPR_LOG2-1:0] dy;
        logic                occupied;
    } spr_slot_t;

    typedef enum logic {IDLE, SCAN} scan_state_t;

    function automatic spr_entry_t decode_entry(input logic [31:0] d);
        spr_entry_t e;
        e.en    = d[D_EN];
        e.sheet = d[D_SHEET_HI:D_SHEET_LO];
        e.flip  = d[D_FLIP];
        e.x     = d[D_X_HI:D_X_LO];
        e.y     = d[D_Y_HI:D_Y_LO];
        e.row   = d[D_ROW_HI:D_ROW_LO];
        e.col   = d[D_COL_HI:D_COL_LO];
        return e;
    endfunction
endpackage

// File: rtl/sprite_slot_match.sv
// One slot's horizontal coverage test and sprite-local column (dx), combinational.
module sprite_slot_match
    import sprite_pkg::*;
(
    input  logic [9:0]          slot_x,
    input  logic                slot_flip,
    input  logic                occupied,
    input  logic [9:0]          pix_x,
    input  logic                pix_valid,
    output logic                hit,
    output logic [SPR_LOG2-1:0] dx
);
    logic [10:0] off;

    // 11-bit difference; sprites near the right edge simply stop at column 1023
    assign off = {1'b0, pix_x} - {1'b0, slot_x};
    assign hit = pix_valid && occupied && (pix_x >= slot_x) && (off < 11'(SPR_SIZE));
    assign dx  = off[SPR_LOG2-1:0] ^ {SPR_LOG2{slot_flip}};
endmodule

// File: rtl/sprite_table.sv
// Double-buffered sprite attribute table with per-line scan and pixel select.
// Optional mirroring is enabled with the SPRITE_FLIP_EN macro.
module sprite_table
    import sprite_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic [9:0]  pix_x,
    input  logic        pix_valid,
    output logic        spr_hit,
    output logic [3:0]  spr_sheet,
    output logic [15:0] spr_rom_addr,
    output logic        spr_overflow,
    output logic        scan_busy
);
`ifdef SPRITE_FLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(N_SLOTS + 1);

    logic [31:0]      shadow [N_ENTRIES];
    logic [31:0]      active [N_ENTRIES];
    spr_slot_t        pend   [N_SLOTS];
    spr_slot_t        cur    [N_SLOTS];
    logic [CNT_W-1:0] pend_cnt;
    scan_state_t      state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [9:0]       line_y_q;

    spr_entry_t  ent;
    logic [10:0] dy_full;
    logic        scan_hit;
    spr_slot_t   new_slot;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (line_start) begin
            state_d = SCAN;
            idx_d   = 3'd0;
        end else if (state_q == SCAN) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = IDLE;
        end
    end

    assign ent      = decode_entry(active[idx_q]);
    assign dy_full  = {1'b0, line_y_q} - {1'b0, ent.y};
    assign scan_hit = (state_q == SCAN) && ent.en && (line_y_q >= ent.y)
                      && (dy_full < 11'(SPR_SIZE));

    always_comb begin
        new_slot          = '0;
        new_slot.x        = ent.x;
        new_slot.sheet    = ent.sheet;
        new_slot.flip     = ent.flip & FLIP_EN;
        new_slot.row      = ent.row;
        new_slot.col      = ent.col;
        new_slot.dy       = dy_full[SPR_LOG2-1:0];
        new_slot.occupied = 1'b1;
    end

    assign scan_busy = (state_q == SCAN);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            for (int i = 0; i < N_SLOTS; i++) begin
                pend[i] <= '0;
                cur[i]  <= '0;
            end
            pend_cnt     <= '0;
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            line_y_q     <= '0;
            spr_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (wr_en) shadow[wr_addr] <= wr_data;
            // commit reads shadow before this cycle's write lands
            if (frame_start) begin
                for (int i = 0; i < N_ENTRIES; i++) active[i] <= shadow[i];
                spr_overflow <= 1'b0;
            end
            if (line_start) begin
                for (int i = 0; i < N_SLOTS; i++) begin
                    cur[i]  <= pend[i];
                    pend[i] <= '0;
                end
                pend_cnt <= '0;
                line_y_q <= line_y;
            end else if (scan_hit) begin
                if (pend_cnt < CNT_W'(N_SLOTS)) begin
                    for (int i = 0; i < N_SLOTS; i++)
                        if (pend_cnt == CNT_W'(i)) pend[i] <= new_slot;
                    pend_cnt <= pend_cnt + 1'b1;
                end else if (!frame_start) begin
                    spr_overflow <= 1'b1;
                end
            end
        end
    end

    logic [N_SLOTS-1:0]  hit_v;
    logic [SPR_LOG2-1:0] dx_v [N_SLOTS];

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_match
        sprite_slot_match u_match (
            .slot_x    (cur[g].x),
            .slot_flip (cur[g].flip),
            .occupied  (cur[g].occupied),
            .pix_x     (pix_x),
            .pix_valid (pix_valid),
            .hit       (hit_v[g]),
            .dx        (dx_v[g])
        );
    end

    logic        sel_hit;
    logic [3:0]  sel_sheet;
    logic [15:0] sel_addr;

    always_comb begin
        sel_hit   = 1'b0;
        sel_sheet = '0;
        sel_addr  = '0;
        // walk downwards so the lowest matching slot is the last assignment
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (hit_v[i]) begin
                sel_hit   = 1'b1;
                sel_sheet = cur[i].sheet;
                sel_addr  = {cur[i].row, cur[i].col, cur[i].dy, dx_v[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spr_hit      <= 1'b0;
            spr_sheet    <= '0;
            spr_rom_addr <= '0;
        end else begin
            spr_hit      <= sel_hit;
            spr_sheet    <= sel_sheet;
            spr_rom_addr <= sel_addr;
        end
    end
endmodule

// File: tb/tb_sprite_table.sv
// Directed self-checking bench for sprite_table.
module tb_sprite_table;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_start;
    logic        line_start;
    logic [9:0]  line_y;
    logic [9:0]  pix_x;
    logic        pix_valid;
    logic        spr_hit;
    logic [3:0]  spr_sheet;
    logic [15:0] spr_rom_addr;
    logic        spr_overflow;
    logic        scan_busy;

    int tests = 0;
    int fails = 0;

    sprite_table dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_start  (frame_start),
        .line_start   (line_start),
        .line_y       (line_y),
        .pix_x        (pix_x),
        .pix_valid    (pix_valid),
        .spr_hit      (spr_hit),
        .spr_sheet    (spr_sheet),
        .spr_rom_addr (spr_rom_addr),
        .spr_overflow (spr_overflow),
        .scan_busy    (scan_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic en, input logic [3:0] sheet, input logic flip,
                                       input logic [9:0] x, input logic [9:0] y,
                                       input logic [2:0] row, input logic [2:0] col);
        return {en, sheet, flip, x, y, row, col};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_line(input logic [9:0] y);
        line_start = 1'b1; line_y = y;
        tick();
        line_start = 1'b0;
        repeat (9) tick();
    endtask

    task automatic pix(input logic [9:0] x, input logic v);
        pix_x = x; pix_valid = v;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        tests++;
        if (spr_hit !== 1'b0 || spr_sheet !== 4'd0 || spr_rom_addr !== 16'd0 ||
            spr_overflow !== 1'b0 || scan_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: hit=%b sheet=%0d addr=%h ovf=%b busy=%b, required all 0",
                     spr_hit, spr_sheet, spr_rom_addr, spr_overflow, scan_busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        write_entry(3'd0, mk(1'b1, 4'd1, 1'b0, 10'd80, 10'd400, 3'd0, 3'd1));
        pulse_frame();
        pulse_line(10'd405);
        pulse_line(10'd405);
        pix(10'd80, 1'b1);
        tests++;
        if (spr_hit !== 1'b1 || spr_sheet !== 4'd1 || spr_rom_addr !== 16'h04A0) begin
            fails++;
            $display("FAIL basic_x80: hit=%b sheet=%0d addr=%h, required 1/1/04a0",
                     spr_hit, spr_sheet, spr_rom_addr);
        end
        pix(10'd111, 1'b1);
        tests++;
        if (spr_hit !== 1'b1 || spr_rom_addr !== 16'h04BF) begin
            fails++;
            $display("FAIL basic_x111: hit=%b addr=%h, required 1/04bf", spr_hit, spr_rom_addr);
        end
        pix(10'd112, 1'b1);
        tests++;
        if (spr_hit !== 1'b0 || spr_sheet !== 4'd0 || spr_rom_addr !== 16'd0) begin
            fails++;
            $display("FAIL basic_x112: hit=%b sheet=%0d addr=%h, required 0/0/0",
                     spr_hit, spr_sheet, spr_rom_addr);
        end
        pix(10'd79, 1'b1);
        tests++;
        if (spr_hit !== 1'b0) begin
            fails++;
            $display("FAIL basic_x79: hit=%b, required 0", spr_hit);
        end
        pix(10'd80, 1'b0);
        tests++;
        if (spr_hit !== 1'b0) begin
            fails++;
            $display("FAIL basic_invalid: hit=%b, required 0", spr_hit);
        end
        // last row of the sprite (dy=31), then one line past it
        pulse_line(10'd431);
        pulse_line(10'd432);
        pix(10'd80, 1'b1);
        tests++;
        if (spr_hit !== 1'b1 || spr_rom_addr !== 16'h07E0) begin
            fails++;
            $display("FAIL basic_dy31: hit=%b addr=%h, required 1/07e0", spr_hit, spr_rom_addr);
        end
        pulse_line(10'd432);
        pix(10'd80, 1'b1);
        tests++;
        if (spr_hit !== 1'b0) begin
            fails++;
            $display("FAIL basic_below: hit=%b, required 0", spr_hit);
        end
    endtask

    task automatic test_flip();
        logic [15:0] exp_addr;
`ifdef SPRITE_FLIP_EN
        exp_addr = 16'h04BE;
`else
        exp_addr = 16'h04A1;
`endif
        write_entry(3'd0, mk(1'b1, 4'd1, 1'b1, 10'd80, 10'd400, 3'd0, 3'd1));
        pulse_frame();
        pulse_line(10'd405);
        pulse_line(10'd405);
        pix(10'd81, 1'b1);
        tests++;
        if (spr_hit !== 1'b1 || spr_rom_addr !== exp_addr) begin
            fails++;
            $display("FAIL flip_x81: hit=%b addr=%h, required 1/%h", spr_hit, spr_rom_addr, exp_addr);
        end
    endtask

    task automatic test_scan_timing();
        int n = 0;
        line_start = 1'b1; line_y = 10'd405;
        tick();
        line_start = 1'b0;
        while (scan_busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL scan_busy_len: cycles=%0d, required 8", n);
        end
    endtask

    task automatic test_shadow();
        write_entry(3'd0, mk(1'b1, 4'd1, 1'b0, 10'd300, 10'd400, 3'd0, 3'd1));
        pulse_line(10'd405);
        pulse_line(10'd405);
        pix(10'd80, 1'b1);
        tests++;
        if (spr_hit !== 1'b1) begin
            fails++;
            $display("FAIL shadow_old_pos: hit=%b, required 1", spr_hit);
        end
        pix(10'd300, 1'b1);
        tests++;
        if (spr_hit !== 1'b0) begin
            fails++;
            $display("FAIL shadow_new_hidden: hit=%b, required 0", spr_hit);
        end
        pulse_frame();
        pulse_line(10'd405);
        pulse_line(10'd405);
        pix(10'd300, 1'b1);
        tests++;
        if (spr_hit !== 1'b1 || spr_rom_addr !== 16'h04A0) begin
            fails++;
            $display("FAIL shadow_new_pos: hit=%b addr=%h, required 1/04a0", spr_hit, spr_rom_addr);
        end
        pix(10'd80, 1'b1);
        tests++;
        if (spr_hit !== 1'b0) begin
            fails++;
            $display("FAIL shadow_old_gone: hit=%b, required 0", spr_hit);
        end
    endtask

    task automatic test_priority();
        write_entry(3'd0, 32'd0);
        write_entry(3'd5, mk(1'b1, 4'd5, 1'b0, 10'd190, 10'd50, 3'd0, 3'd0));
        write_entry(3'd2, mk(1'b1, 4'd2, 1'b0, 10'd185, 10'd50, 3'd0, 3'd0));
        pulse_frame();
        pulse_line(10'd60);
        pulse_line(10'd60);
        pix(10'd200, 1'b1);
        tests++;
        if (spr_hit !== 1'b1 || spr_sheet !== 4'd2) begin
            fails++;
            $display("FAIL priority_sheet: hit=%b sheet=%0d, required 1/2", spr_hit, spr_sheet);
        end
        pix(10'd220, 1'b1);
        tests++;
        if (spr_hit !== 1'b1 || spr_sheet !== 4'd5) begin
            fails++;
            $display("FAIL priority_only5: hit=%b sheet=%0d, required 1/5", spr_hit, spr_sheet);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++)
            write_entry(3'(i), mk(1'b1, 4'(i), 1'b0, 10'(10 + 100 * i), 10'd100, 3'd0, 3'd0));
        pulse_frame();
        pulse_line(10'd110);
        tests++;
        if (spr_overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_set: ovf=%b, required 1", spr_overflow);
        end
        pulse_line(10'd110);
        pix(10'd10, 1'b1);
        tests++;
        if (spr_hit !== 1'b1 || spr_sheet !== 4'd0) begin
            fails++;
            $display("FAIL overflow_slot0: hit=%b sheet=%0d, required 1/0", spr_hit, spr_sheet);
        end
        pix(10'd310, 1'b1);
        tests++;
        if (spr_hit !== 1'b1 || spr_sheet !== 4'd3) begin
            fails++;
            $display("FAIL overflow_slot3: hit=%b sheet=%0d, required 1/3", spr_hit, spr_sheet);
        end
        pix(10'd410, 1'b1);
        tests++;
        if (spr_hit !== 1'b0) begin
            fails++;
            $display("FAIL overflow_drop4: hit=%b, required 0", spr_hit);
        end
        pix(10'd510, 1'b1);
        tests++;
        if (spr_hit !== 1'b0) begin
            fails++;
            $display("FAIL overflow_drop5: hit=%b, required 0", spr_hit);
        end
        pulse_frame();
        tests++;
        if (spr_overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_clear: ovf=%b, required 0", spr_overflow);
        end
    endtask

    task automatic test_reset_mid_scan();
        pix_x = 10'd10; pix_valid = 1'b1;
        line_start = 1'b1; line_y = 10'd110;
        tick();
        line_start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (scan_busy !== 1'b0 || spr_hit !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_scan: busy=%b hit=%b, required 0/0", scan_busy, spr_hit);
        end
        pulse_frame();
        pulse_line(10'd110);
        pulse_line(10'd110);
        pix(10'd10, 1'b1);
        tests++;
        if (spr_hit !== 1'b0 || spr_overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_cleared_table: hit=%b ovf=%b, required 0/0", spr_hit, spr_overflow);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        frame_start = 1'b0; line_start = 1'b0; line_y = '0;
        pix_x = '0; pix_valid = 1'b0;
        test_reset();
        test_basic();
        test_flip();
        test_scan_timing();
        test_shadow();
        test_priority();
        test_overflow();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sprite_table.md
# sprite_table

Sprite attribute store and per-scanline sprite selector that sits directly downstream of the character controllers (player, zombies). It consumes their 32-bit sprite descriptors over an 8-entry write port and drives the pixel mixer with a registered per-pixel sprite hit, sheet id and sprite-ROM address. Descriptors are double-buffered per frame. A scan engine run at each line start picks up to N_SLOTS sprites for the coming line.

## Interface
- N_SLOTS, 4: sprites drawable on one line; range 1..8.
- SPR_LOG2, 5: log2 of sprite edge; sprites are 32x32 px.
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe into shadow table
- wr_addr  in  3  entry index 0..7; lower index = higher draw priority
- wr_data  in  32  descriptor: [31] enable, [30:27] sheet, [26] flip, [25:16] x, [15:6] y, [5:3] row, [2:0] col
- frame_start  in  1  one-cycle pulse at start of vertical blank
- line_start  in  1  one-cycle pulse at start of horizontal blank
- line_y  in  10  line to be prepared, valid with line_start
- pix_x  in  10  current pixel column
- pix_valid  in  1  active-video qualifier
- spr_hit  out  1  a sprite covers the pixel
- spr_sheet  out  4  sheet id of the winning sprite
- spr_rom_addr  out  16  {row, col, dy[4:0], dx[4:0]}
- spr_overflow  out  1  sticky for the frame: more than N_SLOTS sprites on some line
- scan_busy  out  1  scan FSM not IDLE

## Operation
- Shadow table: 8x32 regs. A write with wr_en=1 updates entry wr_addr in the same cycle. Any cycle is legal.
- Commit: when frame_start=1, active <= shadow, whole table in one cycle. A write in the same cycle lands in shadow only and becomes visible next frame. spr_overflow clears on frame_start.
- Scan FSM: IDLE -> SCAN (idx 0..7, one entry per cycle) -> IDLE.
  - line_start enters SCAN with idx=0 and latches line_y.
  - An entry hits if enable=1 and y <= line_y < y+32. Compare in 11-bit, no wrap.
  - A hit is stored into the next free pending slot: x, sheet, flip, row, col, dy=(line_y−y)[4:0].
  - If all slots are full when a further hit occurs, that entry is dropped and spr_overflow is set.
- Slot swap: on line_start, current slots <= pending slots, then pending slots clear. A line is therefore drawn one line_start after it is scanned.
- line_start during SCAN: the swap still happens, and the scan restarts at idx 0 with the new line_y.
- frame_start and line_start in the same cycle: commit takes effect first, and the scan reads the new active table.
- Pixel match, per current slot: match if pix_valid=1 and x <= pix_x < x+32, in 11-bit with no wrap. Entries with x >= 1024−32 cover only columns up to 1023.
  - The lowest occupied slot index wins, which is the lowest table index.
  - dx = pix_x−x, or 31−(pix_x−x) if flip=1.
- Reset: clears shadow, active, current and pending slots to all-zero (enable=0). FSM goes to IDLE, and all outputs go to 0. Reset mid-scan abandons the scan.

## Timing
- Write -> visible: after the next frame_start, then the following line_start scan plus one more line_start swap.
- Scan latency: 8 cycles after line_start. scan_busy is high for exactly those 8 cycles.
- Pixel path: pix_x/pix_valid at cycle t -> spr_hit/spr_sheet/spr_rom_addr at t+1, registered.
- When spr_hit=0, spr_sheet and spr_rom_addr are driven to 0.

## Configuration
- SPRITE_FLIP_EN defined: bit 26 mirrors dx as above.
- SPRITE_FLIP_EN undefined: bit 26 is ignored, dx = pix_x−x always, and the flip field is not stored in slots.

## Structure
- Package sprite_pkg holds:
  - descriptor field bit positions;
  - typedef spr_entry_t (decoded descriptor);
  - typedef spr_slot_t (x, sheet, flip, row, col, dy, occupied);
  - SPR_SIZE = 1<<SPR_LOG2;
  - FSM state enum {IDLE, SCAN}.
- One sub-module, sprite_slot_match: a single slot's x-range compare and dx/flip computation, combinational. It is instantiated N_SLOTS times; the top does the priority select and output register.

## Test plan
- Write entry 0 = {en=1, sheet=1, x=80, y=400, row=0, col=1}. Pulse frame_start. Pulse line_start with line_y=405, then line_start again. Drive pix_x=80 -> next cycle spr_hit=1, spr_sheet=1, spr_rom_addr={0,1,5,0}. pix_x=112 -> spr_hit=0.
- With the same entry and flip=1, SPRITE_FLIP_EN defined: pix_x=81 -> dx=30. Macro undefined -> dx=1.
- Write entries 0..5 all at y=100. Scan line_y=110 -> slots hold entries 0..3 and spr_overflow=1. The next frame_start clears the overflow.
- Write during a frame without frame_start -> output unchanged. After frame_start plus two line_starts, the new position is drawn.
- Entries 2 and 5 overlapping at pix_x=200 -> entry 2's sheet is output. Assert reset mid-scan -> scan_busy=0, spr_hit=0, and all entries are disabled.
